// File: rtl/irq_decode9_pkg.sv
// Shared definitions for the 9-source interrupt decoder: FSM encoding,
// source count and ID field constants.
package irq_decode9_pkg;

  localparam int NUM_SRC = 9;
  localparam int ID_W    = 4;
  localparam logic [ID_W-1:0] ID_NONE = 4'hF;

  // Request/service sequence of the decoder.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/sync_edge9.sv
// 9-bit two-flop synchronizer followed by a rising-edge detector.
// pulse[n] is high for exactly one cycle per synchronized 0->1 transition.
module sync_edge9 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] pulse
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] dly;

  // Synchronizer chain plus one delay stage used for edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign pulse = sync2 & ~dly;

endmodule

// File: rtl/irq_source_decode9.sv
// Interrupt source decoder: collects rising edges from 9 asynchronous event
// lines into sticky pending flags, raises INTERRUPT for enabled sources and
// hands the processor the lowest-numbered enabled pending source as ID.
//
// Handshakes: INTERRUPT is held high until the processor answers with a
// one-cycle INTERRUPT_ACK (or until no enabled source remains pending).
// On ACK the chosen ID is presented with ID_VALID high; ID_VALID stays high
// until the one-cycle ID_READ pulse. ACK outside ASSERT and ID_READ outside
// SERVICE have no effect.
module irq_source_decode9
  import irq_decode9_pkg::*;
#(
  parameter     LOC     = "UNPLACED",
  parameter int NUM_SRC = 9
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] I,
  input  logic [NUM_SRC-1:0] MASK,
  output logic               INTERRUPT,
  input  logic               INTERRUPT_ACK,
  output logic [ID_W-1:0]    ID,
  output logic               ID_VALID,
  input  logic               ID_READ,
  output logic [NUM_SRC-1:0] PENDING
);

  irq_state_t         state;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] pick_oh;
  logic [ID_W-1:0]    pick_id;
  logic               take;
  logic [NUM_SRC-1:0] clr;

  sync_edge9 #(
    .W(NUM_SRC)
  ) u_sync_edge (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (I),
    .pulse(rise)
  );

  assign active = PENDING & MASK;

  // Lowest-index enabled pending source; scanning downward leaves the lowest.
  always_comb begin
    pick_id = ID_NONE;
    pick_oh = '0;
    for (int n = NUM_SRC - 1; n >= 0; n--) begin
      if (active[n]) begin
        pick_id    = ID_W'(n);
        pick_oh    = '0;
        pick_oh[n] = 1'b1;
      end
    end
  end

  assign take = (state == ST_ASSERT) && INTERRUPT_ACK && (|active);
  assign clr  = take ? pick_oh : '0;

  // Pending flags: clear on capture, but a coincident new edge keeps the bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PENDING <= '0;
    end else begin
      PENDING <= (PENDING & ~clr) | rise;
    end
  end

  // Request/service FSM with registered INTERRUPT, ID and ID_VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      INTERRUPT <= 1'b0;
      ID        <= ID_NONE;
      ID_VALID  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|active) begin
            state     <= ST_ASSERT;
            INTERRUPT <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (!(|active)) begin
            // Every requesting source got masked before the ACK arrived.
            state     <= ST_IDLE;
            INTERRUPT <= 1'b0;
          end else if (INTERRUPT_ACK) begin
            state     <= ST_SERVICE;
            INTERRUPT <= 1'b0;
            ID        <= pick_id;
            ID_VALID  <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (ID_READ) begin
            state    <= ST_IDLE;
            ID       <= ID_NONE;
            ID_VALID <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          INTERRUPT <= 1'b0;
          ID        <= ID_NONE;
          ID_VALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_source_decode9.sv
// Bench for irq_source_decode9: directed scenarios with literal expectations,
// a cycle-level behavioural model compared on every falling edge, and an
// expected queue of serviced source IDs.
module tb_irq_source_decode9;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [8:0] I = 9'h000;
  logic [8:0] MASK = 9'h1FF;
  logic       INTERRUPT_ACK = 1'b0;
  logic       ID_READ = 1'b0;
  logic       INTERRUPT;
  logic [3:0] ID;
  logic       ID_VALID;
  logic [8:0] PENDING;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  irq_source_decode9 dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .I            (I),
    .MASK         (MASK),
    .INTERRUPT    (INTERRUPT),
    .INTERRUPT_ACK(INTERRUPT_ACK),
    .ID           (ID),
    .ID_VALID     (ID_VALID),
    .ID_READ      (ID_READ),
    .PENDING      (PENDING)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An event is a 0->1 change of the sampled line; it becomes visible in the
  // pending set three clock edges after the rise. Phase 0 = no request,
  // 1 = request raised and waiting for ACK, 2 = ID handed out, waiting for read.
  logic [8:0] m_pend;
  logic [8:0] samp_1, samp_2, samp_3;
  logic       m_irq;
  logic       m_valid;
  logic [3:0] m_id;
  int         m_phase;

  always @(posedge CLK or negedge RST_N) begin
    logic [8:0] ev;
    logic [8:0] req;
    logic [8:0] served;
    if (!RST_N) begin
      m_pend = '0; samp_1 = '0; samp_2 = '0; samp_3 = '0;
      m_irq = 1'b0; m_valid = 1'b0; m_id = 4'hF; m_phase = 0;
    end else begin
      ev = samp_2 & ~samp_3;
      samp_3 = samp_2; samp_2 = samp_1; samp_1 = I;
      req = m_pend & MASK;
      served = '0;
      if (m_phase == 0) begin
        if (req != 0) begin m_phase = 1; m_irq = 1'b1; end
      end else if (m_phase == 1) begin
        if (req == 0) begin
          m_phase = 0; m_irq = 1'b0;
        end else if (INTERRUPT_ACK) begin
          for (int n = 0; n < 9; n++) begin
            if (req[n]) begin m_id = 4'(n); served[n] = 1'b1; break; end
          end
          m_valid = 1'b1; m_irq = 1'b0; m_phase = 2;
        end
      end else begin
        if (ID_READ) begin m_phase = 0; m_valid = 1'b0; m_id = 4'hF; end
      end
      m_pend = (m_pend & ~served) | ev;
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;

  always @(negedge CLK) begin
    if (RST_N) begin
      chk("model_irq", 16'(INTERRUPT), 16'(m_irq));
      chk("model_id", 16'(ID), 16'(m_id));
      chk("model_valid", 16'(ID_VALID), 16'(m_valid));
      chk("model_pending", 16'(PENDING), 16'(m_pend));
      if (ID_VALID && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_capture", 16'(ID), 16'hFFFF);
        end else begin
          chk("service_order", 16'(ID), 16'(exp_q.pop_front()));
        end
      end
      prev_valid = ID_VALID;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic do_ack();
    INTERRUPT_ACK = 1'b1; tick(1); INTERRUPT_ACK = 1'b0;
  endtask

  task automatic do_read();
    ID_READ = 1'b1; tick(1); ID_READ = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    exp_q = {4'd4, 4'd2, 4'd7, 4'd0, 4'd3, 4'd3, 4'd5, 4'd5};
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(1);
    chk("rst_irq", 16'(INTERRUPT), 16'h0);
    chk("rst_id", 16'(ID), 16'hF);
    chk("rst_valid", 16'(ID_VALID), 16'h0);
    chk("rst_pending", 16'(PENDING), 16'h000);

    // Stray ACK / READ while idle do nothing.
    INTERRUPT_ACK = 1'b1; ID_READ = 1'b1; tick(1);
    INTERRUPT_ACK = 1'b0; ID_READ = 1'b0; tick(1);
    chk("stray_id", 16'(ID), 16'hF);
    chk("stray_irq", 16'(INTERRUPT), 16'h0);

    // Single source 4: pending at edge 3, interrupt at edge 4.
    I = 9'h010;
    tick(2); chk("s4_pend_e2", 16'(PENDING), 16'h000);
    tick(1); chk("s4_pend_e3", 16'(PENDING), 16'h010);
    chk("s4_irq_e3", 16'(INTERRUPT), 16'h0);
    tick(1); chk("s4_irq_e4", 16'(INTERRUPT), 16'h1);
    do_ack();
    chk("s4_id", 16'(ID), 16'h4);
    chk("s4_valid", 16'(ID_VALID), 16'h1);
    chk("s4_pend_clr", 16'(PENDING), 16'h000);
    chk("s4_irq_drop", 16'(INTERRUPT), 16'h0);
    I = 9'h000;
    do_read();
    chk("s4_id_none", 16'(ID), 16'hF);
    chk("s4_valid_clr", 16'(ID_VALID), 16'h0);
    tick(3);
    chk("s4_quiet", 16'(INTERRUPT), 16'h0);

    // Sources 7 and 2 together: lowest first, then re-raise.
    I = 9'h084;
    tick(4); chk("s72_irq", 16'(INTERRUPT), 16'h1);
    chk("s72_pend", 16'(PENDING), 16'h084);
    do_ack();
    chk("s72_id_first", 16'(ID), 16'h2);
    chk("s72_pend_left", 16'(PENDING), 16'h080);
    I = 9'h000;
    do_read();
    chk("s72_gap_low", 16'(INTERRUPT), 16'h0);
    tick(1); chk("s72_reraise", 16'(INTERRUPT), 16'h1);
    do_ack();
    chk("s72_id_second", 16'(ID), 16'h7);
    chk("s72_pend_empty", 16'(PENDING), 16'h000);
    do_read();
    tick(3);

    // Masked source 0 pends silently until enabled.
    MASK = 9'h1FE; I = 9'h001;
    tick(4); chk("m0_pend", 16'(PENDING), 16'h001);
    chk("m0_irq_off", 16'(INTERRUPT), 16'h0);
    tick(2); chk("m0_irq_still_off", 16'(INTERRUPT), 16'h0);
    MASK = 9'h1FF;
    tick(1); chk("m0_irq_on", 16'(INTERRUPT), 16'h1);
    do_ack();
    chk("m0_id", 16'(ID), 16'h0);
    I = 9'h000;
    do_read();
    tick(3);

    // Source 3: mask withdrawn during request, then set-wins on clear.
    I = 9'h008;
    tick(4); chk("m3_irq", 16'(INTERRUPT), 16'h1);
    I = 9'h000; MASK = 9'h1F7;
    tick(1); chk("m3_irq_withdrawn", 16'(INTERRUPT), 16'h0);
    chk("m3_pend_kept", 16'(PENDING), 16'h008);
    tick(1); chk("m3_irq_idle", 16'(INTERRUPT), 16'h0);
    MASK = 9'h1FF;
    tick(1); chk("m3_irq_again", 16'(INTERRUPT), 16'h1);
    I = 9'h008;
    tick(2);
    do_ack();
    chk("m3_id", 16'(ID), 16'h3);
    chk("m3_set_wins", 16'(PENDING), 16'h008);
    chk("m3_irq_drop", 16'(INTERRUPT), 16'h0);
    do_read();
    tick(1); chk("m3_reraise", 16'(INTERRUPT), 16'h1);
    do_ack();
    chk("m3_id_again", 16'(ID), 16'h3);
    chk("m3_pend_empty", 16'(PENDING), 16'h000);
    I = 9'h000;
    do_read();
    tick(3);

    // Source 5: reset during service, line held high across release.
    I = 9'h020;
    tick(4); chk("r5_irq", 16'(INTERRUPT), 16'h1);
    do_ack();
    chk("r5_id", 16'(ID), 16'h5);
    chk("r5_valid", 16'(ID_VALID), 16'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("r5_async_id", 16'(ID), 16'hF);
    chk("r5_async_valid", 16'(ID_VALID), 16'h0);
    chk("r5_async_irq", 16'(INTERRUPT), 16'h0);
    chk("r5_async_pend", 16'(PENDING), 16'h000);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(3); chk("r5_held_pend", 16'(PENDING), 16'h020);
    chk("r5_held_irq_low", 16'(INTERRUPT), 16'h0);
    tick(1); chk("r5_held_irq", 16'(INTERRUPT), 16'h1);
    do_ack();
    chk("r5_held_id", 16'(ID), 16'h5);
    chk("r5_held_pend_clr", 16'(PENDING), 16'h000);
    I = 9'h000;
    do_read();
    tick(5);
    chk("r5_single_event", 16'(INTERRUPT), 16'h0);
    chk("r5_final_pend", 16'(PENDING), 16'h000);

    chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_source_decode9.md
IRQ_SOURCE_DECODE9 -- requirements
Module: irq_source_decode9

Interface
REQ-001 Parameter: LOC, default "UNPLACED", placement annotation only; no functional effect.
REQ-002 Parameter: NUM_SRC, default 9, number of event sources; fixed at 9 in this release.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 I  input  9  asynchronous event lines; a rising edge on I[n] is one event from source n.
REQ-006 MASK  input  9  synchronous enable per source; 1 = source may raise INTERRUPT.
REQ-007 INTERRUPT  output  1  registered interrupt request to the processor.
REQ-008 INTERRUPT_ACK  input  1  one-cycle acknowledge pulse from the processor.
REQ-009 ID  output  4  index 0-8 of the source being serviced; 4'hF when none.
REQ-010 ID_VALID  output  1  ID holds a captured source.
REQ-011 ID_READ  input  1  one-cycle pulse; processor has read ID.
REQ-012 PENDING  output  9  registered pending-event flags, unmasked, for status readback.

Function
REQ-013 Each I[n] SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected by comparing stage 2 with a delay flop.
REQ-014 A detected edge SHALL set PENDING[n] on the 3rd rising CLK edge after I[n] rises (setup met); INTERRUPT SHALL rise on the 4th edge if MASK[n]=1 and the FSM is IDLE.
REQ-015 Multiple edges on one source before service SHALL collapse into one pending event.
REQ-016 FSM states: IDLE, ASSERT, SERVICE.
REQ-017 IDLE -> ASSERT when |(PENDING & MASK); INTERRUPT=1 registered on entry.
REQ-018 ASSERT -> SERVICE on INTERRUPT_ACK: capture the lowest index n with PENDING[n]&MASK[n] into ID, set ID_VALID, clear PENDING[n], drop INTERRUPT, all on the same edge.
REQ-019 ASSERT -> IDLE with INTERRUPT=0 if (PENDING & MASK) becomes zero before ACK (mask change); no ID captured.
REQ-020 SERVICE -> IDLE on ID_READ: ID_VALID=0, ID=4'hF, on the same edge.
REQ-021 After returning to IDLE, any remaining PENDING&MASK SHALL re-raise INTERRUPT on the next edge (min. one cycle low between requests).
REQ-022 INTERRUPT_ACK outside ASSERT and ID_READ outside SERVICE SHALL be ignored.
REQ-023 A new edge on source n coinciding with its clear in REQ-018 SHALL leave PENDING[n]=1 (set wins).
REQ-024 Masked sources SHALL still set PENDING but never raise INTERRUPT or be captured.

Reset
REQ-025 RST_N low SHALL asynchronously clear: sync/delay flops 0, PENDING 0, INTERRUPT 0, ID 4'hF, ID_VALID 0, FSM IDLE.
REQ-026 An I[n] held high across reset release SHALL count as one event.
REQ-027 Reset asserted mid-ASSERT or mid-SERVICE SHALL discard all captured and pending events.

Structure
REQ-028 Shared package irq_decode9_pkg SHALL hold the FSM state encoding, NUM_SRC=9, ID_W=4, ID_NONE=4'hF.
REQ-029 One sub-module, sync_edge9: 9-bit 2-flop synchronizer plus rising-edge detector, output a 9-bit one-cycle pulse vector.
REQ-030 The priority pick (lowest index) SHALL be combinational in the top level; all outputs registered.

Verification
REQ-031 Reset release with I=0, MASK=9'h1FF -> INTERRUPT=0, ID=4'hF, ID_VALID=0, PENDING=0.
REQ-032 Rise I[4] at edge 0 -> PENDING=9'h010 at edge 3, INTERRUPT=1 at edge 4; ACK -> ID=4, ID_VALID=1, PENDING=0, INTERRUPT=0; ID_READ -> ID=4'hF.
REQ-033 Rise I[7] and I[2] together -> first service ID=2, after ID_READ INTERRUPT re-raises one cycle later, second service ID=7.
REQ-034 MASK=9'h1FE, rise I[0] -> PENDING[0]=1, INTERRUPT stays 0; then MASK=9'h1FF -> INTERRUPT=1, ACK yields ID=0.
REQ-035 In ASSERT with only I[3] pending, clear MASK[3] -> INTERRUPT falls, FSM IDLE, PENDING[3] stays 1; new edge on I[3] coinciding with its ACK clear -> PENDING[3] remains 1.
REQ-036 Drop RST_N during SERVICE with ID=5 -> ID=4'hF, ID_VALID=0, INTERRUPT=0 immediately, without a clock edge.
